rtc_bus_sequencer: RTL and testbench
====================================

# rtc_bus_sequencer

Sequences all time and timer traffic on the RTC's multiplexed address/data bus. On a read request it walks the nine RTC registers and commits a coherent snapshot to the register bank. On a write request it transfers a latched copy of the nine register-bank values to the RTC. It sits between the PicoBlaze-facing RTC register bank and the external RTC pins, and produces the `Listo_es` completion strobe that the register bank consumes.

## Interface
- `T_PHASE`, 8: clock cycles per bus phase; legal range 1..255.
- `clk`  in  1: system clock; all logic on rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `start_rd`  in  1: one-cycle request to read all nine RTC registers.
- `start_wr`  in  1: one-cycle request to write all nine RTC registers.
- `ano, mes, dia, horas, minutos, segundos, ht, mt, st`  in  8 each: BCD write data from the register bank.
- `anole, mesle, diale, horasle, minutosle, segundosle, htle, mtle, stle`  out  8 each: BCD read data to the register bank.
- `Listo_es`  out  1: one-cycle pulse when a read or write sequence completes.
- `busy`  out  1: high from request acceptance until the `Listo_es` cycle, inclusive.
- `ad_in`  in  8: RTC bus input data, already synchronised off-block.
- `ad_out`  out  8: RTC bus output data.
- `ad_oe`  out  1: bus output enable for the external tristate buffer.
- `cs_n`, `rd_n`, `wr_n`  out  1 each: RTC chip select, read strobe and write strobe; all active-low.
- `ad_sel`  out  1: 0 selects the address phase, 1 selects the data phase.

## Operation
- Register order is fixed, index 0..8:
  - index 0..5: year 0x26, month 0x25, day 0x24, hours 0x23, minutes 0x22, seconds 0x21.
  - index 6..8: timer-hours 0x43, timer-minutes 0x42, timer-seconds 0x41.
- Main FSM states: `IDLE`, `ADDR_ASSERT`, `ADDR_HOLD`, `DATA_ASSERT`, `DATA_HOLD`, `GAP`, `DONE`.
- `IDLE`:
  - Bus is released: `cs_n`=`rd_n`=`wr_n`=1, `ad_oe`=0, `ad_sel`=0, `ad_out`=0.
  - On `start_wr` or `start_rd`: latch the mode, clear index to 0, go to `ADDR_ASSERT`.
  - A write request also snapshots all nine write inputs into internal registers.
- `ADDR_ASSERT`: `cs_n`=0, `ad_sel`=0, `ad_oe`=1, `ad_out`=address[index], `wr_n`=0.
- `ADDR_HOLD`: as `ADDR_ASSERT`, except `wr_n`=1.
- `DATA_ASSERT`, write mode: `ad_sel`=1, `ad_oe`=1, `ad_out`=snapshot[index], `wr_n`=0.
- `DATA_ASSERT`, read mode: `ad_sel`=1, `ad_oe`=0, `rd_n`=0.
  - `ad_in` is captured into shadow[index] on the last cycle of the state.
- `DATA_HOLD`: strobes high; `cs_n`=0 and `ad_sel`=1 held. Write mode keeps `ad_oe`=1 and `ad_out` stable.
- `GAP`: bus released, same as `IDLE`.
  - If index=8, go to `DONE`; otherwise increment index and go to `ADDR_ASSERT`.
- `DONE` lasts one cycle: `Listo_es`=1, then return to `IDLE`.
  - Read mode: all nine read outputs load from shadow in this same cycle, so the register bank never sees a torn time.
  - Write mode: read outputs are unchanged.
- A phase counter counts 0..T_PHASE-1 in each bus state and advances the state when it reaches T_PHASE-1.
- Boundary conditions:
  - `start_wr` and `start_rd` asserted in the same `IDLE` cycle: write wins; the read is dropped, not queued.
  - Any start outside `IDLE`, including in `DONE`: ignored.
  - Write inputs that change mid-sequence have no effect.
  - Index never wraps; it reaches 8 exactly once per sequence.
  - `reset` mid-sequence: on the next edge the FSM enters `IDLE` and the bus is released. The shadow is discarded, no `Listo_es` is generated, and all outputs take their reset values.

## Timing
- Reset values:
  - `cs_n`, `rd_n`, `wr_n` = 1.
  - `ad_oe`, `ad_sel`, `ad_out` = 0.
  - `busy`, `Listo_es` = 0.
  - All nine read outputs = 8'h00.
- Start sampled at edge k; `ADDR_ASSERT` is visible from edge k+1.
- Each of the five bus states lasts exactly T_PHASE cycles, so one register takes 5·T_PHASE cycles.
- `Listo_es` is high for exactly one cycle at edge k+1+45·T_PHASE. For T_PHASE=8 that is edge k+361.
- The earliest next start is accepted on the cycle after `Listo_es`.
- All bus outputs are registered; there are no combinational paths from `ad_in` or the start inputs to outputs.
- `ad_out` changes only while its strobe is high. It is stable throughout the corresponding assert/hold pair.

## Test plan
- **Reset values:** hold reset 5 cycles, then release with no start → all outputs at reset values; `busy` stays 0.
- **Read sequence:** T_PHASE=8, RTC model returns 8'h13, 02, 01, 15, 29, 43, 23, 40, 57 for the nine addresses; pulse `start_rd` → nine address phases show 0x26…0x41 in order. `Listo_es` pulses 361 cycles after the start, and on that same cycle `anole`=13, `mesle`=02, … `stle`=57. Before that cycle all read outputs stay 00.
- **Write sequence:** inputs `ano`..`st` = 8'h99; pulse `start_wr`, then change all inputs to 8'h11 ten cycles later → bus shows nine address/data pairs with data 8'h99, `wr_n` low T_PHASE cycles per phase, `rd_n` never low, and read outputs unchanged.
- **Simultaneous requests:** `start_rd` and `start_wr` in the same cycle → only a write sequence runs, `rd_n` never asserts, and exactly one `Listo_es` pulse.
- **Start while busy:** `start_rd` 50 cycles into a running read → ignored; only one `Listo_es`, at cycle 361.
- **Reset mid-read:** assert reset during index 4 → next edge has `cs_n`=1, `busy`=0 and all read outputs 00. No `Listo_es`. A subsequent `start_rd` runs a full 361-cycle sequence.

Source files
------------

// File: rtl/rtc_bus_sequencer.sv
// Walks the nine RTC time/timer registers over the multiplexed address/data bus.
// A read commits a coherent snapshot at completion; a write sends a latched copy.
module rtc_bus_sequencer #(
  parameter int unsigned T_PHASE = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_rd,
  input  logic       start_wr,
  input  logic [7:0] ano,
  input  logic [7:0] mes,
  input  logic [7:0] dia,
  input  logic [7:0] horas,
  input  logic [7:0] minutos,
  input  logic [7:0] segundos,
  input  logic [7:0] ht,
  input  logic [7:0] mt,
  input  logic [7:0] st,
  output logic [7:0] anole,
  output logic [7:0] mesle,
  output logic [7:0] diale,
  output logic [7:0] horasle,
  output logic [7:0] minutosle,
  output logic [7:0] segundosle,
  output logic [7:0] htle,
  output logic [7:0] mtle,
  output logic [7:0] stle,
  output logic       Listo_es,
  output logic       busy,
  input  logic [7:0] ad_in,
  output logic [7:0] ad_out,
  output logic       ad_oe,
  output logic       cs_n,
  output logic       rd_n,
  output logic       wr_n,
  output logic       ad_sel
);

  typedef enum logic [2:0] {
    StIdle, StAddrAssert, StAddrHold, StDataAssert, StDataHold, StGap, StDone
  } state_e;

  localparam logic [7:0] PhaseMax = 8'(T_PHASE - 1);

  state_e     state_q, state_d;
  logic [7:0] phase_q, phase_d;
  logic [3:0] index_q, index_d;
  logic       mode_wr_q, mode_wr_d;
  logic       req_q, req_d;
  logic [7:0] snap_q [9];
  logic [7:0] snap_d [9];
  logic [7:0] shadow_q [9];
  logic [7:0] shadow_d [9];
  logic [7:0] rdata_q [9];
  logic [7:0] rdata_d [9];

  logic       cs_n_q, cs_n_d, rd_n_q, rd_n_d, wr_n_q, wr_n_d;
  logic       ad_oe_q, ad_oe_d, ad_sel_q, ad_sel_d;
  logic [7:0] ad_out_q, ad_out_d;
  logic       listo_q, listo_d, busy_q, busy_d;
  logic       phase_last;

  function automatic logic [7:0] reg_addr(input logic [3:0] idx);
    case (idx)
      4'd0:    reg_addr = 8'h26;
      4'd1:    reg_addr = 8'h25;
      4'd2:    reg_addr = 8'h24;
      4'd3:    reg_addr = 8'h23;
      4'd4:    reg_addr = 8'h22;
      4'd5:    reg_addr = 8'h21;
      4'd6:    reg_addr = 8'h43;
      4'd7:    reg_addr = 8'h42;
      4'd8:    reg_addr = 8'h41;
      default: reg_addr = 8'h00;
    endcase
  endfunction

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    index_d    = index_q;
    mode_wr_d  = mode_wr_q;
    req_d      = req_q;
    snap_d     = snap_q;
    shadow_d   = shadow_q;
    rdata_d    = rdata_q;
    phase_last = (phase_q == PhaseMax);

    // Bus outputs are registered from the next state, so the bus tracks state_q exactly.
    unique case (state_q)
      StIdle: begin
        if (req_q) begin
          req_d   = 1'b0;
          phase_d = 8'd0;
          state_d = StAddrAssert;
        end else if (start_wr || start_rd) begin
          req_d     = 1'b1;
          mode_wr_d = start_wr;
          index_d   = 4'd0;
          if (start_wr) snap_d = '{ano, mes, dia, horas, minutos, segundos, ht, mt, st};
        end
      end
      StAddrAssert, StAddrHold, StDataAssert, StDataHold, StGap: begin
        if (!phase_last) begin
          phase_d = phase_q + 8'd1;
        end else begin
          phase_d = 8'd0;
          unique case (state_q)
            StAddrAssert: state_d = StAddrHold;
            StAddrHold:   state_d = StDataAssert;
            StDataAssert: begin
              state_d = StDataHold;
              if (!mode_wr_q) shadow_d[index_q] = ad_in;
            end
            StDataHold:   state_d = StGap;
            default: begin
              if (index_q == 4'd8) begin
                state_d = StDone;
                if (!mode_wr_q) rdata_d = shadow_q;
              end else begin
                index_d = index_q + 4'd1;
                state_d = StAddrAssert;
              end
            end
          endcase
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    cs_n_d   = 1'b1;
    rd_n_d   = 1'b1;
    wr_n_d   = 1'b1;
    ad_oe_d  = 1'b0;
    ad_sel_d = 1'b0;
    ad_out_d = 8'h00;
    listo_d  = 1'b0;
    busy_d   = req_d || (state_d != StIdle);

    unique case (state_d)
      StAddrAssert, StAddrHold: begin
        cs_n_d   = 1'b0;
        ad_oe_d  = 1'b1;
        ad_out_d = reg_addr(index_d);
        wr_n_d   = (state_d != StAddrAssert);
      end
      StDataAssert, StDataHold: begin
        cs_n_d   = 1'b0;
        ad_sel_d = 1'b1;
        if (mode_wr_d) begin
          ad_oe_d  = 1'b1;
          ad_out_d = snap_d[index_d];
          wr_n_d   = (state_d != StDataAssert);
        end else begin
          rd_n_d   = (state_d != StDataAssert);
        end
      end
      StDone:  listo_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      phase_q   <= 8'd0;
      index_q   <= 4'd0;
      mode_wr_q <= 1'b0;
      req_q     <= 1'b0;
      for (int i = 0; i < 9; i++) begin
        snap_q[i]   <= 8'h00;
        shadow_q[i] <= 8'h00;
        rdata_q[i]  <= 8'h00;
      end
      cs_n_q   <= 1'b1;
      rd_n_q   <= 1'b1;
      wr_n_q   <= 1'b1;
      ad_oe_q  <= 1'b0;
      ad_sel_q <= 1'b0;
      ad_out_q <= 8'h00;
      listo_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      index_q   <= index_d;
      mode_wr_q <= mode_wr_d;
      req_q     <= req_d;
      snap_q    <= snap_d;
      shadow_q  <= shadow_d;
      rdata_q   <= rdata_d;
      cs_n_q    <= cs_n_d;
      rd_n_q    <= rd_n_d;
      wr_n_q    <= wr_n_d;
      ad_oe_q   <= ad_oe_d;
      ad_sel_q  <= ad_sel_d;
      ad_out_q  <= ad_out_d;
      listo_q   <= listo_d;
      busy_q    <= busy_d;
    end
  end

  assign cs_n       = cs_n_q;
  assign rd_n       = rd_n_q;
  assign wr_n       = wr_n_q;
  assign ad_oe      = ad_oe_q;
  assign ad_sel     = ad_sel_q;
  assign ad_out     = ad_out_q;
  assign Listo_es   = listo_q;
  assign busy       = busy_q;
  assign anole      = rdata_q[0];
  assign mesle      = rdata_q[1];
  assign diale      = rdata_q[2];
  assign horasle    = rdata_q[3];
  assign minutosle  = rdata_q[4];
  assign segundosle = rdata_q[5];
  assign htle       = rdata_q[6];
  assign mtle       = rdata_q[7];
  assign stle       = rdata_q[8];

endmodule

// File: tb/tb_rtc_bus_sequencer.sv
// Directed bench for rtc_bus_sequencer with a small RTC bus model and bus monitor.
module tb_rtc_bus_sequencer;

  logic       clk = 1'b0;
  logic       reset, start_rd, start_wr;
  logic [7:0] wdat;
  logic [7:0] anole, mesle, diale, horasle, minutosle, segundosle, htle, mtle, stle;
  logic       Listo_es, busy;
  logic [7:0] ad_in, ad_out;
  logic       ad_oe, cs_n, rd_n, wr_n, ad_sel;

  always #5 clk = ~clk;

  rtc_bus_sequencer #(.T_PHASE(8)) dut (
    .clk(clk), .reset(reset), .start_rd(start_rd), .start_wr(start_wr),
    .ano(wdat), .mes(wdat), .dia(wdat), .horas(wdat), .minutos(wdat), .segundos(wdat),
    .ht(wdat), .mt(wdat), .st(wdat),
    .anole(anole), .mesle(mesle), .diale(diale), .horasle(horasle), .minutosle(minutosle),
    .segundosle(segundosle), .htle(htle), .mtle(mtle), .stle(stle),
    .Listo_es(Listo_es), .busy(busy), .ad_in(ad_in), .ad_out(ad_out), .ad_oe(ad_oe),
    .cs_n(cs_n), .rd_n(rd_n), .wr_n(wr_n), .ad_sel(ad_sel)
  );

  localparam logic [71:0] ExpAddr = 72'h26_25_24_23_22_21_43_42_41;
  localparam logic [71:0] ExpRead = 72'h13_02_01_15_29_43_23_40_57;

  logic [71:0] rd_all;
  assign rd_all = {anole, mesle, diale, horasle, minutosle, segundosle, htle, mtle, stle};

  // RTC model: latches the address phase, returns fixed BCD contents.
  logic [7:0] rtc_addr = 8'h00;
  always @(posedge clk) if (!cs_n && !ad_sel && ad_oe) rtc_addr <= ad_out;
  always_comb begin
    case (rtc_addr)
      8'h26: ad_in = 8'h13;
      8'h25: ad_in = 8'h02;
      8'h24: ad_in = 8'h01;
      8'h23: ad_in = 8'h15;
      8'h22: ad_in = 8'h29;
      8'h21: ad_in = 8'h43;
      8'h43: ad_in = 8'h23;
      8'h42: ad_in = 8'h40;
      8'h41: ad_in = 8'h57;
      default: ad_in = 8'hee;
    endcase
  end

  int         edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  logic [7:0] addr_q[$];
  logic [7:0] data_q[$];
  int         rd_low, wr_low, listo_cnt, listo_edge;
  bit         early_nz;
  logic       prev_cs_n = 1'b1, prev_ad_sel = 1'b0;

  always @(negedge clk) begin
    if (!cs_n && !ad_sel && prev_cs_n) addr_q.push_back(ad_out);
    if (!cs_n && ad_sel && !prev_ad_sel && ad_oe) data_q.push_back(ad_out);
    if (!rd_n) rd_low++;
    if (!wr_n) wr_low++;
    if (Listo_es) begin
      listo_cnt++;
      listo_edge = edge_n;
    end
    if (rd_all != 72'h0 && !Listo_es) early_nz = 1'b1;
    prev_cs_n   = cs_n;
    prev_ad_sel = ad_sel;
  end

  int n_vec = 0;
  int n_err = 0;
  int start_edge;
  bit seen;

  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic clr_mon();
    addr_q.delete();
    data_q.delete();
    rd_low = 0; wr_low = 0; listo_cnt = 0; listo_edge = 0; early_nz = 1'b0;
  endtask

  function automatic logic [71:0] pack9(input logic [7:0] q[$]);
    logic [71:0] v = '0;
    for (int i = 0; i < 9; i++) v = {v[63:0], (i < q.size()) ? q[i] : 8'hxx};
    return v;
  endfunction

  task automatic pulse(input bit rd, input bit wr);
    start_rd = rd;
    start_wr = wr;
    start_edge = edge_n + 1;
    tick();
    start_rd = 1'b0;
    start_wr = 1'b0;
  endtask

  task automatic wait_listo(input int bound);
    seen = 1'b0;
    for (int i = 0; i < bound && !seen; i++) begin
      if (Listo_es) seen = 1'b1;
      else tick();
    end
    if (Listo_es) seen = 1'b1;
  endtask

  initial begin
    reset = 1'b1; start_rd = 1'b0; start_wr = 1'b0; wdat = 8'h00;
    clr_mon();
    tick(5);
    reset = 1'b0;
    tick(3);
    check("rst_cs_n", cs_n, 1'b1);
    check("rst_rd_wr_n", {rd_n, wr_n}, 2'b11);
    check("rst_oe_sel", {ad_oe, ad_sel}, 2'b00);
    check("rst_ad_out", ad_out, 8'h00);
    check("rst_busy_listo", {busy, Listo_es}, 2'b00);
    check("rst_read_out", rd_all, 72'h0);

    // Read sequence
    clr_mon();
    pulse(1'b1, 1'b0);
    check("rd_busy", busy, 1'b1);
    wait_listo(500);
    check("rd_listo_seen", seen, 1'b1);
    check("rd_latency", listo_edge - start_edge, 361);
    check("rd_data", rd_all, ExpRead);
    check("rd_addr_cnt", addr_q.size(), 9);
    check("rd_addr_seq", pack9(addr_q), ExpAddr);
    check("rd_rd_low", rd_low, 72);
    check("rd_wr_low", wr_low, 72);
    check("rd_no_early", early_nz, 1'b0);
    tick();
    check("rd_after", {Listo_es, busy}, 2'b00);

    // Write sequence, inputs changed mid-flight
    clr_mon();
    wdat = 8'h99;
    pulse(1'b0, 1'b1);
    tick(9);
    wdat = 8'h11;
    wait_listo(500);
    check("wr_listo_seen", seen, 1'b1);
    check("wr_latency", listo_edge - start_edge, 361);
    check("wr_addr_seq", pack9(addr_q), ExpAddr);
    check("wr_data_cnt", data_q.size(), 9);
    check("wr_data_seq", pack9(data_q), {9{8'h99}});
    check("wr_wr_low", wr_low, 144);
    check("wr_rd_low", rd_low, 0);
    check("wr_read_kept", rd_all, ExpRead);

    // Simultaneous requests: write wins
    tick(2);
    clr_mon();
    pulse(1'b1, 1'b1);
    wait_listo(500);
    tick(400);
    check("sim_listo_cnt", listo_cnt, 1);
    check("sim_rd_low", rd_low, 0);
    check("sim_data_seq", pack9(data_q), {9{8'h11}});
    check("sim_read_kept", rd_all, ExpRead);

    // Start while busy is ignored
    clr_mon();
    pulse(1'b1, 1'b0);
    tick(49);
    start_rd = 1'b1;
    tick();
    start_rd = 1'b0;
    wait_listo(500);
    check("busy_latency", listo_edge - start_edge, 361);
    tick(400);
    check("busy_listo_cnt", listo_cnt, 1);
    check("busy_idle", busy, 1'b0);

    // Reset during index 4 of a read
    pulse(1'b1, 1'b0);
    tick(170);
    check("mid_cs_active", cs_n, 1'b0);
    reset = 1'b1;
    tick();
    check("mid_rst_cs_n", cs_n, 1'b1);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_read", rd_all, 72'h0);
    reset = 1'b0;
    clr_mon();
    tick(400);
    check("mid_no_listo", listo_cnt, 0);
    clr_mon();
    pulse(1'b1, 1'b0);
    wait_listo(500);
    check("mid_re_latency", listo_edge - start_edge, 361);
    check("mid_re_data", rd_all, ExpRead);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
